// File: rtl/hwpe_tcdm_responder_pkg.sv
// Shared types and LFSR constants for the TCDM responder.
// The LFSR items are only used when TCDM_RESPONDER_STALL_EN is defined.
package hwpe_tcdm_responder_package;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;

  typedef struct packed {
    logic [31:0] r_data;
    logic        r_valid;
  } tcdm_resp_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {^(state & LFSR_TAPS), state[15:1]};
  endfunction

endpackage

// File: rtl/hwpe_tcdm_responder_if.sv
// TCDM bundle between HWPE initiator ports (master) and the responder (slave).
interface hwpe_tcdm_responder_if #(
  parameter int NB_PORTS   = 3,
  parameter int ADDR_WIDTH = 32
);

  logic [NB_PORTS-1:0]                 tcdm_req;
  logic [NB_PORTS-1:0]                 tcdm_gnt;
  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0] tcdm_add;
  logic [NB_PORTS-1:0]                 tcdm_wen;
  logic [NB_PORTS-1:0][3:0]            tcdm_be;
  logic [NB_PORTS-1:0][31:0]           tcdm_data;
  logic [NB_PORTS-1:0][31:0]           tcdm_r_data;
  logic [NB_PORTS-1:0]                 tcdm_r_valid;

  modport master (
    output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
    input  tcdm_gnt, tcdm_r_data, tcdm_r_valid
  );

  modport slave (
    input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
    output tcdm_gnt, tcdm_r_data, tcdm_r_valid
  );

endinterface

// File: rtl/hwpe_tcdm_responder_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starting after the last granted port.
module hwpe_rr_arbiter #(
  parameter int NB_PORTS = 3,
  parameter int LAST_W   = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NB_PORTS-1:0] req,
  input  logic                stall,
  output logic [NB_PORTS-1:0] gnt,
  output logic [LAST_W-1:0]   gnt_idx,
  output logic                grant_any
);

  logic [LAST_W-1:0] last;
  logic [LAST_W-1:0] cand;

  // Grant is also masked by rst_n so nothing is granted while reset is held
  always_comb begin
    gnt       = '0;
    gnt_idx   = last;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NB_PORTS; k++) begin
      cand = LAST_W'((int'(last) + 1 + k) % NB_PORTS);
      if (!grant_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        grant_any = 1'b1;
      end
    end
    if (!rst_n || stall) begin
      gnt       = '0;
      grant_any = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= LAST_W'(NB_PORTS - 1);
    end else if (grant_any) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/hwpe_tcdm_responder.sv
// Single-ported word memory serving NB_PORTS TCDM initiators through a round-robin arbiter.
// Define TCDM_RESPONDER_STALL_EN to inject LFSR-driven grant stalls.
module hwpe_tcdm_responder
  import hwpe_tcdm_responder_package::*;
#(
  parameter int NB_PORTS   = 3,
  parameter int MEM_WORDS  = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hwpe_tcdm_responder_if.slave tcdm
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int LAST_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

  logic [NB_PORTS-1:0]   gnt;
  logic [LAST_W-1:0]     gnt_idx;
  logic                  grant_any;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] gnt_add;
  tcdm_req_t             sel;
  logic [IDX_W-1:0]      word_idx;
  logic [31:0]           rd_word;
  logic                  unused_add_bits;
  logic [31:0]           mem [MEM_WORDS];
  tcdm_resp_t            resp_q [NB_PORTS];

`ifdef TCDM_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  hwpe_rr_arbiter #(
    .NB_PORTS (NB_PORTS),
    .LAST_W   (LAST_W)
  ) i_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (tcdm.tcdm_req),
    .stall     (stall),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .grant_any (grant_any)
  );

  assign tcdm.tcdm_gnt = gnt;
  assign gnt_add       = tcdm.tcdm_add[gnt_idx];

  always_comb begin
    sel      = '0;
    sel.add  = 32'(gnt_add);
    sel.wen  = tcdm.tcdm_wen[gnt_idx];
    sel.be   = tcdm.tcdm_be[gnt_idx];
    sel.data = tcdm.tcdm_data[gnt_idx];
  end

  // Upper address bits wrap and the byte offset is ignored
  assign word_idx        = sel.add[2 +: IDX_W];
  assign unused_add_bits = ^{sel.add[31:IDX_W+2], sel.add[1:0]};
  assign rd_word         = mem[word_idx];

  always_ff @(posedge clk) begin
    if (grant_any && !sel.wen) begin
      for (int k = 0; k < 4; k++) begin
        if (sel.be[k]) begin
          mem[word_idx][8*k +: 8] <= sel.data[8*k +: 8];
        end
      end
    end
  end

  // Response register: async reset drops any response that was due
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NB_PORTS; p++) begin
        resp_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NB_PORTS; p++) begin
        resp_q[p].r_valid <= gnt[p];
        resp_q[p].r_data  <= (gnt[p] && sel.wen) ? rd_word : 32'h0;
      end
    end
  end

  always_comb begin
    tcdm.tcdm_r_valid = '0;
    tcdm.tcdm_r_data  = '0;
    for (int p = 0; p < NB_PORTS; p++) begin
      tcdm.tcdm_r_valid[p] = resp_q[p].r_valid;
      tcdm.tcdm_r_data[p]  = resp_q[p].r_data;
    end
  end

endmodule

// File: tb/tb_hwpe_tcdm_responder.sv
// Directed bench for hwpe_tcdm_responder: vector table plus reset and stall sequences.
// With TCDM_RESPONDER_STALL_EN defined only the LFSR stall sequence runs.
module tb_hwpe_tcdm_responder;

  localparam int NB_PORTS = 3;

  logic clk = 1'b0;
  logic rst_n;

  hwpe_tcdm_responder_if #(.NB_PORTS(NB_PORTS), .ADDR_WIDTH(32)) tcdm ();

  hwpe_tcdm_responder #(
    .NB_PORTS   (NB_PORTS),
    .MEM_WORDS  (1024),
    .ADDR_WIDTH (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tcdm  (tcdm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  wen;
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] data;
    logic [2:0]  exp_gnt;
    logic [2:0]  exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add_vec(input logic [2:0] req, input logic [2:0] wen, input logic [31:0] add,
                         input logic [3:0] be, input logic [31:0] data, input logic [2:0] exp_gnt,
                         input logic [2:0] exp_rv, input logic [31:0] exp_rd);
    vec_t v;
    v.req = req; v.wen = wen; v.add = add; v.be = be; v.data = data;
    v.exp_gnt = exp_gnt; v.exp_rv = exp_rv; v.exp_rd = exp_rd;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input logic [2:0] req, input logic [2:0] wen, input logic [31:0] add,
                                input logic [3:0] be, input logic [31:0] data);
    tcdm.tcdm_req = req;
    tcdm.tcdm_wen = wen;
    for (int p = 0; p < NB_PORTS; p++) begin
      tcdm.tcdm_add[p]  = add;
      tcdm.tcdm_be[p]   = be;
      tcdm.tcdm_data[p] = data;
    end
  endtask

  // r_data is expected on the valid ports only; all others must read 0
  task automatic check_output(input string name, input logic [2:0] exp_gnt,
                              input logic [2:0] exp_rv, input logic [31:0] exp_rd);
    logic [31:0] want;
    checks++;
    if (tcdm.tcdm_gnt !== exp_gnt) begin
      errors++;
      $display("[TB] FAIL %s gnt: got %b expected %b", name, tcdm.tcdm_gnt, exp_gnt);
    end
    checks++;
    if (tcdm.tcdm_r_valid !== exp_rv) begin
      errors++;
      $display("[TB] FAIL %s r_valid: got %b expected %b", name, tcdm.tcdm_r_valid, exp_rv);
    end
    for (int p = 0; p < NB_PORTS; p++) begin
      want = exp_rv[p] ? exp_rd : 32'h0;
      checks++;
      if (tcdm.tcdm_r_data[p] !== want) begin
        errors++;
        $display("[TB] FAIL %s r_data[%0d]: got %h expected %h", name, p, tcdm.tcdm_r_data[p], want);
      end
    end
  endtask

  initial begin
    // req, wen, add, be, data, exp_gnt, exp_rv, exp_rd
    add_vec(3'b001, 3'b000, 32'h10,   4'hF, 32'hDEADBEEF, 3'b001, 3'b000, 32'h0);
    add_vec(3'b001, 3'b111, 32'h10,   4'hF, 32'h0,        3'b001, 3'b001, 32'h0);
    add_vec(3'b000, 3'b111, 32'h0,    4'h0, 32'h0,        3'b000, 3'b001, 32'hDEADBEEF);
    add_vec(3'b001, 3'b000, 32'h20,   4'hF, 32'h11223344, 3'b001, 3'b000, 32'h0);
    add_vec(3'b001, 3'b000, 32'h20,   4'h5, 32'hAABBCCDD, 3'b001, 3'b001, 32'h0);
    add_vec(3'b001, 3'b111, 32'h20,   4'h0, 32'h0,        3'b001, 3'b001, 32'h0);
    add_vec(3'b000, 3'b111, 32'h0,    4'h0, 32'h0,        3'b000, 3'b001, 32'h11BB33DD);
    add_vec(3'b100, 3'b111, 32'h10,   4'h0, 32'h0,        3'b100, 3'b000, 32'h0);
    add_vec(3'b111, 3'b111, 32'h10,   4'h0, 32'h0,        3'b001, 3'b100, 32'hDEADBEEF);
    add_vec(3'b111, 3'b111, 32'h10,   4'h0, 32'h0,        3'b010, 3'b001, 32'hDEADBEEF);
    add_vec(3'b111, 3'b111, 32'h10,   4'h0, 32'h0,        3'b100, 3'b010, 32'hDEADBEEF);
    add_vec(3'b111, 3'b111, 32'h10,   4'h0, 32'h0,        3'b001, 3'b100, 32'hDEADBEEF);
    add_vec(3'b110, 3'b100, 32'h40,   4'hF, 32'h5,        3'b010, 3'b001, 32'hDEADBEEF);
    add_vec(3'b100, 3'b100, 32'h40,   4'hF, 32'h5,        3'b100, 3'b010, 32'h0);
    add_vec(3'b000, 3'b111, 32'h0,    4'h0, 32'h0,        3'b000, 3'b100, 32'h5);
    add_vec(3'b001, 3'b000, 32'h1004, 4'hF, 32'hCAFEF00D, 3'b001, 3'b000, 32'h0);
    add_vec(3'b001, 3'b111, 32'h0004, 4'h0, 32'h0,        3'b001, 3'b001, 32'h0);
    add_vec(3'b000, 3'b111, 32'h0,    4'h0, 32'h0,        3'b000, 3'b001, 32'hCAFEF00D);
    add_vec(3'b001, 3'b111, 32'h1007, 4'h0, 32'h0,        3'b001, 3'b000, 32'h0);
    add_vec(3'b000, 3'b111, 32'h0,    4'h0, 32'h0,        3'b000, 3'b001, 32'hCAFEF00D);

    rst_n = 1'b0;
    apply_stimulus(3'b111, 3'b111, 32'h0, 4'h0, 32'h0);
    #1;
    check_output("reset_start", 3'b000, 3'b000, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_hold", 3'b000, 3'b000, 32'h0);
    @(negedge clk);

`ifdef TCDM_RESPONDER_STALL_EN
    begin
      logic [15:0] model;
      logic        exp_g;
      logic        prev_g;
      model  = 16'hACE1;
      prev_g = 1'b0;
      rst_n  = 1'b1;
      apply_stimulus(3'b001, 3'b111, 32'h10, 4'h0, 32'h0);
      for (int c = 0; c < 64; c++) begin
        #1;
        exp_g = (model[1:0] != 2'b00);
        checks++;
        if (tcdm.tcdm_gnt !== {2'b00, exp_g}) begin
          errors++;
          $display("[TB] FAIL stall_gnt cycle %0d: got %b expected %b", c, tcdm.tcdm_gnt, {2'b00, exp_g});
        end
        checks++;
        if (tcdm.tcdm_r_valid !== {2'b00, prev_g}) begin
          errors++;
          $display("[TB] FAIL stall_rvalid cycle %0d: got %b expected %b", c, tcdm.tcdm_r_valid, {2'b00, prev_g});
        end
        prev_g = exp_g;
        model  = {model[0] ^ model[2] ^ model[3] ^ model[5], model[15:1]};
        @(negedge clk);
      end
    end
`else
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].req, vecs[i].wen, vecs[i].add, vecs[i].be, vecs[i].data);
      #1;
      check_output($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_rv, vecs[i].exp_rd);
      @(negedge clk);
    end

    // Reset asserted while a read response is due: it must vanish, and arbitration restarts at port 0
    apply_stimulus(3'b010, 3'b111, 32'h10, 4'h0, 32'h0);
    #1;
    check_output("pre_reset_grant", 3'b010, 3'b000, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    apply_stimulus(3'b111, 3'b111, 32'h10, 4'h0, 32'h0);
    #1;
    check_output("reset_drop", 3'b000, 3'b000, 32'h0);
    @(negedge clk);
    #1;
    check_output("reset_mid_hold", 3'b000, 3'b000, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("post_reset_first", 3'b001, 3'b000, 32'h0);
    @(negedge clk);
    apply_stimulus(3'b000, 3'b111, 32'h0, 4'h0, 32'h0);
    #1;
    check_output("post_reset_resp", 3'b000, 3'b001, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    check_output("post_reset_idle", 3'b000, 3'b000, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
